soml_metric_max: RTL
====================

# soml_metric_max

Downstream consumer of the YGA1 matched-filter stage in the SOML decoder. It accepts a stream of signed complex terms (Y·G·A products), one candidate at a time. For each candidate it sums a fixed number of terms and computes the exact squared magnitude of the sum. Across a block of candidates it reports the index and metric of the largest one, which the symbol slicer uses.

## Interface
Parameters:
- W, 16: width of each signed real/imag input component.
- L, 4: complex terms summed per candidate.
- K, 16: candidates per decision block.
- ACC_W, W+$clog2(L): signed accumulator width per component.
- MET_W, 2*ACC_W: unsigned metric width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low. Asserted when 0.
- in_valid  in  1  input term valid.
- in_ready  out  1  block can accept a term.
- in_r  in  W  signed real part of the term.
- in_i  in  W  signed imaginary part of the term.
- out_valid  out  1  decision valid. Held until accepted.
- out_ready  in  1  consumer accepts the decision.
- best_idx  out  $clog2(K)  index of the winning candidate.
- best_metric  out  MET_W  winning acc_r²+acc_i².

## Operation
- A term transfers on a rising edge when in_valid && in_ready.
- States and transitions:
  - ACC: in_ready=1. Each transfer adds in_r/in_i into acc_r/acc_i (sign-extended) and increments term_cnt. The L-th transfer goes to SQR with term_cnt=0.
  - SQR: in_ready=0. Registers met = acc_r²+acc_i² via the magnitude sub-block. Clears acc_r/acc_i. Goes to CMP.
  - CMP: in_ready=0. If cand_cnt==0 or met > best_metric, loads best_metric=met and best_idx=cand_cnt. Ties keep the earlier (lower) index. If cand_cnt==K-1, goes to DONE with cand_cnt=0; otherwise increments cand_cnt and returns to ACC.
  - DONE: out_valid=1, in_ready=0, best_* held stable. On out_valid && out_ready, goes to ACC. best_* keep their value until the first CMP of the next block overwrites them.
- Arithmetic is exact:
  - No saturation.
  - The ACC_W accumulator cannot overflow for L terms.
  - A (-2^(ACC_W-1))² sum fits MET_W unsigned.
- in_valid low in ACC stalls with no state change. Gaps between terms are allowed.
- Reset (rst=0), at any time including mid-block:
  - state=ACC; acc, term_cnt, cand_cnt cleared.
  - best_idx=0, best_metric=0, out_valid=0.
  - in_ready=0 while rst is low, 1 in the first cycle after release.
  - A partial block is discarded. No decision is produced for it.

## Timing
- Throughput: one term per cycle in ACC. Each candidate costs L+2 cycles minimum.
- A minimum block takes K·(L+2) cycles, plus the DONE handshake.
- Latency: out_valid rises in the cycle after the second edge following the edge that accepts the last term of candidate K-1 (ACC→SQR→CMP→DONE).
- Handshake: out_valid never drops without out_ready. in_ready is a registered state decode with no combinational path from in_valid or out_ready.
- DONE with out_ready=1: transfer at the next edge, and in_ready=1 in the following cycle. No term is accepted in the handshake cycle.

## Structure
- Shared package soml_pkg:
  - W, L, K, ACC_W, MET_W defaults.
  - State enum {ACC, SQR, CMP, DONE}.
  - Shared with the YGA stages.
- Sub-module cplx_sq_mag: combinational acc_r²+acc_i² of ACC_W signed inputs, producing an MET_W unsigned result. The parent registers the output in SQR.

## Test plan
1. Reset: hold rst=0 for 3 cycles → out_valid=0, best_idx=0, best_metric=0, in_ready=0. Release → in_ready=1 next cycle.
2. Clear winner: candidate 5 gets 4×(100,0); all others get 4×(1,1) → best_idx=5, best_metric=160000, out_valid exactly 2 edges after the last accepted term.
3. Tie: candidates 2 and 9 get 4×(1,1) (metric 32); all others get 4×(0,0) → best_idx=2, best_metric=32.
4. Extremes: every term is (-32768,-32768) → acc=-131072 per component, best_metric=34359738368, best_idx=0, no wrap.
5. Backpressure:
   - Random in_valid gaps, with out_ready held low for 10 cycles in DONE → best_* stable and in_ready=0 throughout.
   - After release, the next block decodes correctly with no term lost or duplicated.
6. Reset mid-block:
   - Assert rst after candidate 7 → all outputs return to reset values.
   - The next full block with winner 3 (4×(50,50), metric 80000) reports best_idx=3, best_metric=80000.

Source files
------------

// File: rtl/soml_pkg.sv
// Shared SOML decoder constants and the candidate-metric FSM state type.
// The YGA stages import the same package so widths stay consistent.
package soml_pkg;

    localparam int SOML_W     = 16;
    localparam int SOML_L     = 4;
    localparam int SOML_K     = 16;
    localparam int SOML_ACC_W = SOML_W + $clog2(SOML_L);
    localparam int SOML_MET_W = 2 * SOML_ACC_W;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        SQR  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } soml_state_e;

endpackage

// File: rtl/cplx_sq_mag.sv
// Combinational exact squared magnitude of a signed complex accumulator.
// Operands are sign-extended to MET_W so neither product nor sum can wrap.
module cplx_sq_mag
    import soml_pkg::*;
#(
    parameter int ACC_W = SOML_ACC_W,
    parameter int MET_W = SOML_MET_W
) (
    input  logic signed [ACC_W-1:0] a_r,
    input  logic signed [ACC_W-1:0] a_i,
    output logic        [MET_W-1:0] mag
);

    logic signed [MET_W-1:0] ext_r;
    logic signed [MET_W-1:0] ext_i;
    logic signed [MET_W-1:0] sq_r;
    logic signed [MET_W-1:0] sq_i;

    always_comb begin
        ext_r = MET_W'(a_r);
        ext_i = MET_W'(a_i);
        sq_r  = ext_r * ext_r;
        sq_i  = ext_i * ext_i;
        // Each square is at most 2^(2*ACC_W-2), so the unsigned sum fits MET_W.
        mag   = $unsigned(sq_r) + $unsigned(sq_i);
    end

endmodule

// File: rtl/soml_metric_max.sv
// Sums L complex terms per candidate, squares the magnitude, and reports the
// index/metric of the largest candidate over a block of K candidates.
module soml_metric_max
    import soml_pkg::*;
#(
    parameter int W     = SOML_W,
    parameter int L     = SOML_L,
    parameter int K     = SOML_K,
    parameter int ACC_W = W + $clog2(L),
    parameter int MET_W = 2 * ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_r,
    input  logic [W-1:0]         in_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(K)-1:0] best_idx,
    output logic [MET_W-1:0]     best_metric,
    output logic [1:0]           dbg_state
);

    localparam int TC_W = (L > 1) ? $clog2(L) : 1;
    localparam int CI_W = $clog2(K);

    // Handshake: a term moves on a rising edge with in_valid && in_ready; a
    // decision moves with out_valid && out_ready. in_ready and out_valid are
    // flops decoded from the next state, so neither depends on in_valid or
    // out_ready combinationally, and out_valid holds until it is accepted.

    soml_state_e             state;
    soml_state_e             state_nxt;
    logic [TC_W-1:0]         term_cnt;
    logic [CI_W-1:0]         cand_cnt;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_i;
    logic [MET_W-1:0]        met;
    logic [MET_W-1:0]        mag;
    logic                    term_xfer;
    logic                    last_term;
    logic                    last_cand;
    logic                    take_best;

    cplx_sq_mag #(
        .ACC_W (ACC_W),
        .MET_W (MET_W)
    ) u_sq_mag (
        .a_r (acc_r),
        .a_i (acc_i),
        .mag (mag)
    );

    assign term_xfer = in_valid && in_ready;
    assign last_term = (term_cnt == TC_W'(L - 1));
    assign last_cand = (cand_cnt == CI_W'(K - 1));
    // Strict compare keeps the lower index on ties.
    assign take_best = (cand_cnt == '0) || (met > best_metric);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (term_xfer && last_term) state_nxt = SQR;
            SQR:     state_nxt = CMP;
            CMP:     state_nxt = last_cand ? DONE : ACC;
            DONE:    if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ACC;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            term_cnt    <= '0;
            cand_cnt    <= '0;
            acc_r       <= '0;
            acc_i       <= '0;
            met         <= '0;
            best_idx    <= '0;
            best_metric <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == ACC);
            out_valid <= (state_nxt == DONE);
            case (state)
                ACC: begin
                    if (term_xfer) begin
                        acc_r    <= acc_r + ACC_W'(signed'(in_r));
                        acc_i    <= acc_i + ACC_W'(signed'(in_i));
                        term_cnt <= last_term ? '0 : term_cnt + 1'b1;
                    end
                end
                SQR: begin
                    met   <= mag;
                    acc_r <= '0;
                    acc_i <= '0;
                end
                CMP: begin
                    if (take_best) begin
                        best_metric <= met;
                        best_idx    <= cand_cnt;
                    end
                    cand_cnt <= last_cand ? '0 : cand_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
